// File: rtl/spi_flash_pkg.sv
// Constants and state encoding shared by the SPI flash responder and controller.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int unsigned ADDR_BYTES = 3;
  localparam int unsigned DUMMY_BITS = 8;
  localparam int unsigned ADDR_BITS  = ADDR_BYTES * 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CMD    = ST_CMD,
    ADDR   = ST_ADDR,
    DUMMY  = ST_DUMMY,
    DATA   = ST_DATA,
    IGNORE = ST_IGNORE
  } spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchronizer for an asynchronous input, with single-cycle rise/fall pulses.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
      prev   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign sync   = stages[SYNC_STAGES-1];
  assign rise_c = sync & ~prev;
  assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash slave serving READ (0x03) from a preloadable byte array.
// Define SPI_FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = 4096,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              CSbar,
  input  logic              DI,
  output logic              DO,
  output logic              DO_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy
);

  logic [7:0] mem [MEM_SIZE];

  logic sck_sync, sck_rise_c, sck_fall_c;
  logic cs_sync, cs_rise_c, cs_fall_c;
  logic sck_rise_act_c, sck_fall_act_c;
  logic [SYNC_STAGES-1:0] di_stages;
  logic di;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (SCK),
    .sync   (sck_sync),
    .rise_c (sck_rise_c),
    .fall_c (sck_fall_c)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (CSbar),
    .sync   (cs_sync),
    .rise_c (cs_rise_c),
    .fall_c (cs_fall_c)
  );

  // DI runs through the same depth as SCK so a sampled bit lines up with its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) di_stages <= '0;
    else     di_stages <= {di_stages[SYNC_STAGES-2:0], DI};
  end
  assign di = di_stages[SYNC_STAGES-1];

  assign sck_rise_act_c = sck_rise_c & ~cs_sync;
  assign sck_fall_act_c = sck_fall_c & ~cs_sync;

  // Host preload port; unreset storage, always accepted.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  spi_state_t          state;
  logic [4:0]          bit_cnt;
  logic [ADDR_BITS-2:0] shift_in;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          shift_out;
`ifdef SPI_FAST_READ_EN
  logic                fast;
`endif

  // Protocol FSM; a fetch reads mem before any same-cycle host write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      addr      <= '0;
      shift_out <= '0;
      DO        <= 1'b0;
      DO_en     <= 1'b0;
      busy      <= 1'b0;
`ifdef SPI_FAST_READ_EN
      fast      <= 1'b0;
`endif
    end else if (cs_rise_c) begin
      state   <= IDLE;
      bit_cnt <= '0;
      DO      <= 1'b0;
      DO_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall_c) begin
            busy     <= 1'b1;
            bit_cnt  <= '0;
            shift_in <= '0;
`ifdef SPI_FAST_READ_EN
            fast     <= 1'b0;
`endif
            // Mode 0 needs SCK idle low at selection; anything else is not served.
            state    <= sck_sync ? IGNORE : CMD;
          end
        end
        CMD: begin
          if (sck_rise_act_c) begin
            shift_in <= {shift_in[ADDR_BITS-3:0], di};
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              if ({shift_in[6:0], di} == CMD_READ) begin
                state <= ADDR;
`ifdef SPI_FAST_READ_EN
              end else if ({shift_in[6:0], di} == CMD_FAST_READ) begin
                state <= ADDR;
                fast  <= 1'b1;
`endif
              end else begin
                state <= IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ADDR: begin
          if (sck_rise_act_c && bit_cnt != 5'(ADDR_BITS)) begin
            shift_in <= {shift_in[ADDR_BITS-3:0], di};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(ADDR_BITS - 1)) addr <= ADDR_W'({shift_in, di});
          end else if (sck_fall_act_c && bit_cnt == 5'(ADDR_BITS)) begin
`ifdef SPI_FAST_READ_EN
            if (fast) begin
              state   <= DUMMY;
              bit_cnt <= '0;
            end else
`endif
            begin
              shift_out <= mem[addr];
              DO        <= mem[addr][7];
              DO_en     <= 1'b1;
              addr      <= addr + 1'b1;
              bit_cnt   <= '0;
              state     <= DATA;
            end
          end
        end
`ifdef SPI_FAST_READ_EN
        DUMMY: begin
          if (sck_rise_act_c && bit_cnt != 5'(DUMMY_BITS)) begin
            bit_cnt <= bit_cnt + 5'd1;
          end else if (sck_fall_act_c && bit_cnt == 5'(DUMMY_BITS)) begin
            shift_out <= mem[addr];
            DO        <= mem[addr][7];
            DO_en     <= 1'b1;
            addr      <= addr + 1'b1;
            bit_cnt   <= '0;
            state     <= DATA;
          end
        end
`endif
        DATA: begin
          if (sck_fall_act_c) begin
            if (bit_cnt == 5'd7) begin
              shift_out <= mem[addr];
              DO        <= mem[addr][7];
              addr      <= addr + 1'b1;
              bit_cnt   <= '0;
            end else begin
              shift_out <= {shift_out[6:0], 1'b0};
              DO        <= shift_out[6];
              bit_cnt   <= bit_cnt + 5'd1;
            end
          end
        end
        IGNORE: begin
          DO    <= 1'b0;
          DO_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: bit-banged SPI master plus a byte-array memory model.
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

  localparam int unsigned MEM_SIZE = 4096;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned HALF     = 5;

  logic clk = 1'b0;
  logic rst, SCK, CSbar, DI, DO, DO_en, load_en, busy;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0] load_data;

  always #5 clk = ~clk;

  spi_flash_responder #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .CSbar(CSbar), .DI(DI), .DO(DO), .DO_en(DO_en),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  logic [7:0] model [MEM_SIZE];
  int total = 0;
  int bad = 0;

  logic pend_load = 1'b0;
  int pend_wait = 0;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0] pend_data;

  logic [7:0] rx [16];
  logic rx_en_all, rx_en_any, rx_do_any, pre_en_any;

  function automatic logic [7:0] exp_byte(input logic [23:0] a, input int i);
    int idx;
    idx = (int'(a[ADDR_W-1:0]) + i) % MEM_SIZE;
    return model[idx];
  endfunction

  task automatic host_load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    model[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    SCK = 1'b0; CSbar = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    CSbar = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // One SCK period: DI set with SCK low, DO sampled just before the rising edge.
  task automatic xfer_bit(input logic mosi, output logic miso, output logic en);
    DI = mosi;
    if (pend_load) begin
      if (pend_wait == 0) begin
        load_en = 1'b1; load_addr = pend_addr; load_data = pend_data;
        model[pend_addr] = pend_data;
        pend_load = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    @(negedge clk);
    load_en = 1'b0;
    repeat (HALF - 1) @(negedge clk);
    miso = DO; en = DO_en;
    SCK = 1'b1;
    repeat (HALF) @(negedge clk);
    SCK = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] mosi, output logic [7:0] miso,
                           output logic en_all, output logic en_any, output logic do_any);
    logic b, e;
    en_all = 1'b1; en_any = 1'b0; do_any = 1'b0; miso = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(mosi[i], b, e);
      miso[i] = b;
      en_all &= e; en_any |= e; do_any |= b;
    end
  endtask

  task automatic run_read(input logic [7:0] cmd, input logic [23:0] a, input int dummy, input int nbytes);
    logic [7:0] junk;
    logic ea, en, dn;
    pre_en_any = 1'b0; rx_en_all = 1'b1; rx_en_any = 1'b0; rx_do_any = 1'b0;
    cs_low();
    xfer_byte(cmd, junk, ea, en, dn); pre_en_any |= en;
    xfer_byte(a[23:16], junk, ea, en, dn); pre_en_any |= en;
    xfer_byte(a[15:8], junk, ea, en, dn); pre_en_any |= en;
    xfer_byte(a[7:0], junk, ea, en, dn); pre_en_any |= en;
    for (int d = 0; d < dummy; d++) begin
      xfer_byte(8'hFF, junk, ea, en, dn); pre_en_any |= en;
    end
    for (int i = 0; i < nbytes; i++) begin
      xfer_byte(8'h00, rx[i], ea, en, dn);
      rx_en_all &= ea; rx_en_any |= en; rx_do_any |= dn;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; SCK = 1'b0; CSbar = 1'b0; DI = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    total++; if (DO !== 1'b0) begin bad++; $display("FAIL reset_do: got %b want 0", DO); end
    total++; if (DO_en !== 1'b0) begin bad++; $display("FAIL reset_do_en: got %b want 0", DO_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cs_low_through_reset: busy got %b want 0", busy); end
    CSbar = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic_read();
    host_load(12'h010, 8'h13); host_load(12'h011, 8'h37);
    host_load(12'h012, 8'hC0); host_load(12'h013, 8'hDE);
    run_read(CMD_READ, 24'h000010, 0, 4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx[i] !== exp_byte(24'h000010, i)) begin
        bad++; $display("FAIL basic_byte%0d: got %h want %h", i, rx[i], exp_byte(24'h000010, i));
      end
    end
    total++; if (rx_en_all !== 1'b1) begin bad++; $display("FAIL basic_do_en: got %b want 1", rx_en_all); end
    total++; if (pre_en_any !== 1'b0) begin bad++; $display("FAIL basic_pre_do_en: got %b want 0", pre_en_any); end
    cs_high();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    host_load(12'hFFF, 8'hAA); host_load(12'h000, 8'h55);
    run_read(CMD_READ, 24'hFFFFFF, 0, 2);
    total++; if (rx[0] !== exp_byte(24'hFFFFFF, 0)) begin bad++; $display("FAIL wrap_byte0: got %h want %h", rx[0], exp_byte(24'hFFFFFF, 0)); end
    total++; if (rx[1] !== exp_byte(24'hFFFFFF, 1)) begin bad++; $display("FAIL wrap_byte1: got %h want %h", rx[1], exp_byte(24'hFFFFFF, 1)); end
    total++; if (rx_en_all !== 1'b1) begin bad++; $display("FAIL wrap_do_en: got %b want 1", rx_en_all); end
    cs_high();
  endtask

  task automatic test_bad_cmd();
    run_read(8'h9F, 24'($urandom), 0, 2);
    total++; if (pre_en_any !== 1'b0) begin bad++; $display("FAIL badcmd_pre_en: got %b want 0", pre_en_any); end
    total++; if (rx_en_any !== 1'b0) begin bad++; $display("FAIL badcmd_do_en: got %b want 0", rx_en_any); end
    total++; if (rx_do_any !== 1'b0) begin bad++; $display("FAIL badcmd_do: got %b want 0", rx_do_any); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL badcmd_busy: got %b want 1", busy); end
    @(negedge clk);
    CSbar = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL badcmd_busy_drop: got %b want 0", busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    logic [7:0] junk;
    logic ea, en, dn, b, e;
    cs_low();
    xfer_byte(CMD_READ, junk, ea, en, dn);
    for (int i = 0; i < 12; i++) xfer_bit(1'b1, b, e);
    cs_high();
    run_read(CMD_READ, 24'h000011, 0, 1);
    total++; if (rx[0] !== exp_byte(24'h000011, 0)) begin bad++; $display("FAIL abort_fresh_read: got %h want %h", rx[0], exp_byte(24'h000011, 0)); end
    cs_high();
  endtask

  task automatic test_fast_read();
    run_read(CMD_FAST_READ, 24'h000010, 1, 2);
    total++; if (pre_en_any !== 1'b0) begin bad++; $display("FAIL fast_pre_do_en: got %b want 0", pre_en_any); end
`ifdef SPI_FAST_READ_EN
    total++; if (rx[0] !== exp_byte(24'h000010, 0)) begin bad++; $display("FAIL fast_byte0: got %h want %h", rx[0], exp_byte(24'h000010, 0)); end
    total++; if (rx[1] !== exp_byte(24'h000010, 1)) begin bad++; $display("FAIL fast_byte1: got %h want %h", rx[1], exp_byte(24'h000010, 1)); end
    total++; if (rx_en_all !== 1'b1) begin bad++; $display("FAIL fast_do_en: got %b want 1", rx_en_all); end
`else
    total++; if (rx_en_any !== 1'b0) begin bad++; $display("FAIL fast_disabled_do_en: got %b want 0", rx_en_any); end
    total++; if (rx_do_any !== 1'b0) begin bad++; $display("FAIL fast_disabled_do: got %b want 0", rx_do_any); end
`endif
    cs_high();
  endtask

  task automatic test_reset_mid_data();
    logic b, e;
    logic [7:0] m;
    run_read(CMD_READ, 24'h000010, 0, 1);
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, b, e);
    repeat (4) @(negedge clk);
    m = exp_byte(24'h000010, 1);
    total++; if (DO_en !== 1'b1) begin bad++; $display("FAIL midrst_pre_do_en: got %b want 1", DO_en); end
    total++; if (DO !== m[4]) begin bad++; $display("FAIL midrst_pre_do: got %b want %b", DO, m[4]); end
    #2 rst = 1'b1;
    #1;
    total++; if (DO !== 1'b0) begin bad++; $display("FAIL midrst_do: got %b want 0", DO); end
    total++; if (DO_en !== 1'b0) begin bad++; $display("FAIL midrst_do_en: got %b want 0", DO_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk);
    CSbar = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    run_read(CMD_READ, 24'h000012, 0, 1);
    total++; if (rx[0] !== exp_byte(24'h000012, 0)) begin bad++; $display("FAIL midrst_after: got %h want %h", rx[0], exp_byte(24'h000012, 0)); end
    cs_high();
  endtask

  task automatic test_random_reads();
    int base, n;
    logic [23:0] a;
    for (int k = 0; k < 8; k++) begin
      base = int'($urandom_range(0, MEM_SIZE - 1));
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) host_load(ADDR_W'((base + j) % MEM_SIZE), 8'($urandom));
      a = {12'($urandom), 12'(base)};
      run_read(CMD_READ, a, 0, n);
      for (int j = 0; j < n; j++) begin
        total++;
        if (rx[j] !== exp_byte(a, j)) begin
          bad++; $display("FAIL rand%0d_byte%0d: addr %h got %h want %h", k, j, a, rx[j], exp_byte(a, j));
        end
      end
      total++; if (rx_en_all !== 1'b1) begin bad++; $display("FAIL rand%0d_do_en: got %b want 1", k, rx_en_all); end
      cs_high();
    end
  endtask

  task automatic test_load_midstream();
    int base;
    logic [23:0] a;
    base = int'($urandom_range(0, MEM_SIZE - 1));
    for (int j = 0; j < 3; j++) host_load(ADDR_W'((base + j) % MEM_SIZE), 8'($urandom));
    a = 24'(base);
    pend_addr = ADDR_W'((base + 2) % MEM_SIZE);
    pend_data = ~model[(base + 2) % MEM_SIZE];
    pend_wait = 34;
    pend_load = 1'b1;
    run_read(CMD_READ, a, 0, 3);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (rx[j] !== exp_byte(a, j)) begin
        bad++; $display("FAIL midload_byte%0d: got %h want %h", j, rx[j], exp_byte(a, j));
      end
    end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_wrap();
    test_bad_cmd();
    test_abort();
    test_fast_read();
    test_reset_mid_data();
    test_random_reads();
    test_load_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
